xor_parity_sched: RTL

- Scheduler that shares one bit-serial XOR-reduction engine (single xor2 feedback stage) between NREQ requesters.
- Each requester submits a DW-bit word; the engine folds it one bit per cycle and returns even parity tagged with the requester ID.
- Sits between multiple parity/ECC producers and the shared XOR datapath; replaces per-requester XOR trees in area-constrained hd logic.

---
 rtl/xor_parity_sched_pkg.sv | 13 +
 rtl/xor_parity_sched_rr_arb.sv | 37 +++
 rtl/xor_parity_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/xor_parity_sched_pkg.sv
// Shared types and width helpers for the xor_parity_sched block.
package xor_parity_sched_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int BUSY_CNT_W = 16;

   // Never returns 0, so a degenerate single-entry field still has one bit.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/xor_parity_sched_rr_arb.sv
// Combinational round-robin arbiter: the first valid request above ptr wins,
// wrapping modulo NREQ.
module xor_parity_sched_rr_arb
   import xor_parity_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]          req,
   input  logic [clog2w(NREQ)-1:0]  ptr,
   output logic [NREQ-1:0]          gnt,
   output logic [clog2w(NREQ)-1:0]  idx
);

   localparam int IDW = clog2w(NREQ);

   // Distance from ptr+1 ranks each requester; the smallest valid distance wins.
   always_comb begin
      int best_d;
      int best_i;
      int d;
      best_d = NREQ;
      best_i = 0;
      d      = 0;
      for (int i = 0; i < NREQ; i++) begin
         d = (i + NREQ - 1 - int'(ptr)) % NREQ;
         if (req[i] && d < best_d) begin
            best_d = d;
            best_i = i;
         end
      end
      gnt = '0;
      for (int i = 0; i < NREQ; i++)
         gnt[i] = (best_d < NREQ) && (best_i == i);
      idx = IDW'(best_i);
   end

endmodule

// File: rtl/xor_parity_sched.sv
// Shares one bit-serial XOR engine between NREQ requesters, returning parity tagged by ID.
// Optional macro XOR_PARITY_SCHED_BUSY_CNT_EN adds a saturating BUSY_CNT of SHIFT cycles.
module xor_parity_sched
   import xor_parity_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 8
) (
   input  logic                      CLK,
   input  logic                      RESETB,
   input  logic [NREQ-1:0]           REQ_VALID,
   input  logic [NREQ*DW-1:0]        REQ_DATA,
   output logic [NREQ-1:0]           REQ_READY,
   output logic                      RSP_VALID,
   output logic [clog2w(NREQ)-1:0]   RSP_ID,
   output logic                      RSP_PARITY,
`ifdef XOR_PARITY_SCHED_BUSY_CNT_EN
   output logic [BUSY_CNT_W-1:0]     BUSY_CNT,
`endif
   input  logic                      RSP_READY
);

   localparam int IDW = clog2w(NREQ);
   localparam int CW  = clog2w(DW + 1);

   state_t                   state;
   logic [DW-1:0]            sh;
   logic                     acc;
   logic [CW-1:0]            cnt;
   logic [IDW-1:0]           id;
   logic [IDW-1:0]           ptr;
   logic [NREQ-1:0]          gnt;
   logic [IDW-1:0]           gidx;
   logic [NREQ-1:0][DW-1:0]  req_data_a;

   assign req_data_a = REQ_DATA;

   xor_parity_sched_rr_arb #(.NREQ(NREQ)) u_arb (
      .req (REQ_VALID),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gidx)
   );

   // Gated by RESETB so no grant strobe leaks out while reset is held.
   assign REQ_READY = (state == IDLE && RESETB) ? gnt : '0;

   always_ff @(posedge CLK) begin
      if (!RESETB) begin
         state      <= IDLE;
         sh         <= '0;
         acc        <= 1'b0;
         cnt        <= '0;
         id         <= '0;
         ptr        <= IDW'(NREQ - 1);
         RSP_VALID  <= 1'b0;
         RSP_ID     <= '0;
         RSP_PARITY <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|REQ_VALID) begin
                  sh    <= req_data_a[gidx];
                  acc   <= 1'b0;
                  cnt   <= '0;
                  id    <= gidx;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= acc ^ sh[0];
               sh  <= sh >> 1;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(DW - 1)) begin
                  state      <= DONE;
                  RSP_VALID  <= 1'b1;
                  RSP_ID     <= id;
                  RSP_PARITY <= acc ^ sh[0];
               end
            end
            DONE: begin
               if (RSP_READY) begin
                  ptr       <= id;
                  RSP_VALID <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef XOR_PARITY_SCHED_BUSY_CNT_EN
   logic [BUSY_CNT_W-1:0] busy_cnt;

   always_ff @(posedge CLK) begin
      if (!RESETB)
         busy_cnt <= '0;
      else if (state == SHIFT && busy_cnt != {BUSY_CNT_W{1'b1}})
         busy_cnt <= busy_cnt + BUSY_CNT_W'(1);
   end

   assign BUSY_CNT = busy_cnt;
`endif

endmodule
